// File: rtl/uart_key_hold_decoder.sv
// Maps received UART key codes to per-player held levels that persist for a tick-based hold window.
// Optional release-code handling (bit7 set) is enabled by defining KEY_RELEASE_CODE_EN.
module uart_key_hold_decoder #(
    parameter int NUM_PLAYERS     = 2,
    parameter int KEYS_PER_PLAYER = 5,
    parameter logic [8*NUM_PLAYERS*KEYS_PER_PLAYER-1:0] KEYMAP = 80'h0D_6C_6A_6B_69_20_64_61_73_77,
    parameter bit CASE_FOLD       = 1'b1,
    parameter int TICK_DIV        = 100000,
    parameter int HOLD_TICKS      = 600
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [7:0]                               rx_data,
    input  logic                                     rx_valid,
    output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0]   key_state,
    output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0]   key_press,
    output logic                                     any_key,
    output logic [7:0]                               last_code
);
    localparam int N  = NUM_PLAYERS * KEYS_PER_PLAYER;
    localparam int CW = $clog2(HOLD_TICKS + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_TICKS);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    function automatic logic [7:0] fold(input logic [7:0] b);
        if (CASE_FOLD && b >= 8'h41 && b <= 8'h5A) return b | 8'h20;
        return b;
    endfunction

    logic [PW-1:0]         pre_q, pre_d;
    logic                  tick;
    logic [7:0]            code;
    logic                  is_rel;
    logic [N-1:0]          match, rel_m;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]          state_q, state_d;
    logic [N-1:0]          press_q, press_d;
    logic [7:0]            last_q, last_d;

    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_comb begin
`ifdef KEY_RELEASE_CODE_EN
        code   = fold({1'b0, rx_data[6:0]});
        is_rel = rx_data[7];
`else
        code   = fold(rx_data);
        is_rel = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            match[i] = rx_valid && !is_rel && (code == KEYMAP[8*i +: 8]);
            rel_m[i] = rx_valid &&  is_rel && (code == KEYMAP[8*i +: 8]);
        end
    end

    // A match reloads the full window even when it coincides with a tick.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];
            if (match[i]) begin
                cnt_d[i]   = HOLD_LD;
                state_d[i] = 1'b1;
            end else if (rel_m[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = 1'b0;
            end else if (tick && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
                if (cnt_q[i] == CW'(1)) state_d[i] = 1'b0;
            end
        end
        press_d = state_d & ~state_q;
        last_d  = (|match) ? code : last_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            state_q <= '0;
            press_q <= '0;
            last_q  <= 8'h00;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            press_q <= press_d;
            last_q  <= last_d;
        end
    end

    assign key_state = state_q;
    assign key_press = press_q;
    assign any_key   = |state_q;
    assign last_code = last_q;
endmodule
